free_list: RTL and testbench

Physical-register free list for the out-of-order core. It sits directly upstream of the rename stage and supplies one unallocated physical tag per renamed destination through the `free_list_read` / `free_list_tag` / `free_list_valid` handshake. At commit, the ROB returns the previous mapping of the retiring destination here. Storage is a circular FIFO that a small FSM fills after reset or flush.

---
 rtl/ooo_pkg.sv | 8 +
 rtl/free_list.sv | 90 +++++++++
 tb/tb_free_list.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ooo_pkg.sv
// ooo_pkg: shared out-of-order core sizing constants and types
package ooo_pkg;
    localparam int NUM_PHYSICAL_REGS = 64;
    localparam int NUM_ARCH_REGS     = 32;
    localparam int TAG_WIDTH         = 6;
    typedef logic [TAG_WIDTH-1:0] phys_tag_t;
    typedef enum logic {FL_INIT, FL_RUN} fl_state_e;
endpackage

// File: rtl/free_list.sv
// free_list: circular FIFO of unallocated physical tags, refilled by an INIT sweep after reset or flush
module free_list
    import ooo_pkg::*;
#(
    localparam int DEPTH = NUM_PHYSICAL_REGS - NUM_ARCH_REGS,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            free_list_read,
    output phys_tag_t       free_list_tag,
    output logic            free_list_valid,
    input  logic            release_valid,
    input  phys_tag_t       release_tag,
    input  logic            flush,
    output logic [CW-1:0]   free_count,
    output logic            init_done,
    output logic            overflow_err
);
    fl_state_e       state, state_nx;
    logic [PW-1:0]   head, tail, init_idx;
    logic [CW-1:0]   count;
    phys_tag_t       mem [DEPTH];
    logic            pop, push, init_last;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign init_last       = init_idx == PW'(DEPTH - 1);
    assign init_done       = state == FL_RUN;
    assign free_list_valid = init_done && count != '0;
    assign free_list_tag   = free_list_valid ? mem[head] : '0;
    assign pop             = free_list_read && free_list_valid;
    assign push            = init_done && release_valid && (count < CW'(DEPTH) || pop);
    assign free_count      = count;

    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = FL_INIT;
        else if (state == FL_INIT && init_last)
            state_nx = FL_RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= FL_INIT;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            init_idx     <= '0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            init_idx <= '0;
        end else if (state == FL_INIT) begin
            // tail stays at 0 through the sweep, which is exactly the wrapped position after a full fill
            init_idx <= wrap_inc(init_idx);
            if (init_last)
                count <= CW'(DEPTH);
        end else begin
            if (pop)
                head <= wrap_inc(head);
            if (push)
                tail <= wrap_inc(tail);
            count <= count + CW'(push) - CW'(pop);
            if (release_valid && !push)
                overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            if (state == FL_INIT)
                mem[init_idx] <= TAG_WIDTH'(NUM_ARCH_REGS) + TAG_WIDTH'(init_idx);
            else if (push)
                mem[tail] <= release_tag;
        end
    end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed self-checking bench for free_list
module tb_free_list;
    import ooo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, free_list_read, free_list_valid, release_valid, flush, init_done, overflow_err;
    phys_tag_t   free_list_tag, release_tag;
    logic [5:0]  free_count;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [5:0]  q [$];

    free_list dut (
        .clk(clk), .rst_n(rst_n), .free_list_read(free_list_read), .free_list_tag(free_list_tag),
        .free_list_valid(free_list_valid), .release_valid(release_valid), .release_tag(release_tag),
        .flush(flush), .free_count(free_count), .init_done(init_done), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; free_list_read = 1'b0; release_valid = 1'b0; release_tag = '0; flush = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(free_list_valid), 0);
        chk("rst_tag", 32'(free_list_tag), 0);
        chk("rst_count", 32'(free_count), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_ovf", 32'(overflow_err), 0);

        // reads and releases during INIT are ignored without raising overflow
        rst_n = 1'b1; release_valid = 1'b1; release_tag = 6'd3; free_list_read = 1'b1;
        for (int i = 0; i < 31; i++) tick();
        chk("init31_valid", 32'(free_list_valid), 0);
        chk("init31_done", 32'(init_done), 0);
        release_valid = 1'b0; free_list_read = 1'b0;
        tick();
        chk("init_valid", 32'(free_list_valid), 1);
        chk("init_done", 32'(init_done), 1);
        chk("init_count", 32'(free_count), 32);
        chk("init_tag", 32'(free_list_tag), 32);
        chk("init_ovf", 32'(overflow_err), 0);

        free_list_read = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("drain_tag", 32'(free_list_tag), 32'(32 + i));
            tick();
        end
        free_list_read = 1'b0;
        chk("empty_valid", 32'(free_list_valid), 0);
        chk("empty_count", 32'(free_count), 0);
        free_list_read = 1'b1;
        tick();
        free_list_read = 1'b0;
        chk("read_empty_count", 32'(free_count), 0);
        chk("read_empty_valid", 32'(free_list_valid), 0);
        chk("read_empty_tag", 32'(free_list_tag), 0);

        release_valid = 1'b1; release_tag = 6'd5; free_list_read = 1'b1;
        chk("nobypass_valid", 32'(free_list_valid), 0);
        tick();
        release_valid = 1'b0; free_list_read = 1'b0;
        chk("rel5_valid", 32'(free_list_valid), 1);
        chk("rel5_tag", 32'(free_list_tag), 5);
        chk("rel5_count", 32'(free_count), 1);
        free_list_read = 1'b1;
        tick();
        free_list_read = 1'b0;
        chk("rel5_pop_count", 32'(free_count), 0);

        release_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            release_tag = 6'(10 + i);
            tick();
        end
        chk("fill_count", 32'(free_count), 32);
        chk("fill_tag", 32'(free_list_tag), 10);
        release_tag = 6'd7;
        tick();
        chk("ovf_set", 32'(overflow_err), 1);
        chk("ovf_count", 32'(free_count), 32);
        chk("ovf_tag", 32'(free_list_tag), 10);
        release_tag = 6'd9; free_list_read = 1'b1;
        tick();
        release_valid = 1'b0;
        chk("swap_count", 32'(free_count), 32);
        for (int i = 1; i < 32; i++) begin
            chk("swap_drain_tag", 32'(free_list_tag), 32'(10 + i));
            tick();
        end
        chk("tail9_tag", 32'(free_list_tag), 9);
        chk("tail9_count", 32'(free_count), 1);
        tick();
        free_list_read = 1'b0;
        chk("tail9_empty", 32'(free_count), 0);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_init", 32'(init_done), 0);
        for (int i = 0; i < 31; i++) tick();
        chk("flush31_valid", 32'(free_list_valid), 0);
        tick();
        chk("reinit_count", 32'(free_count), 32);
        free_list_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("pop10_tag", 32'(free_list_tag), 32'(32 + i));
            tick();
        end
        free_list_read = 1'b0;
        chk("pop10_count", 32'(free_count), 22);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 31; i++) tick();
        chk("restart31_valid", 32'(free_list_valid), 0);
        tick();
        chk("restart_valid", 32'(free_list_valid), 1);
        chk("restart_tag", 32'(free_list_tag), 32);
        chk("restart_count", 32'(free_count), 32);
        chk("restart_ovf", 32'(overflow_err), 1);

        for (int i = 0; i < 32; i++) q.push_back(6'(32 + i));
        free_list_read = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("pre_wrap_tag", 32'(free_list_tag), 32'(q.pop_front()));
            tick();
        end
        free_list_read = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                free_list_read = 1'b1;
                chk("wrap_tag", 32'(free_list_tag), 32'(q.pop_front()));
            end else begin
                release_valid = 1'b1;
                release_tag = 6'(i * 3 + 1);
                if (q.size() < 32) q.push_back(release_tag);
            end
            tick();
            free_list_read = 1'b0; release_valid = 1'b0;
            chk("wrap_count", 32'(free_count), 32'(q.size()));
            chk("wrap_count_max", 32'(free_count <= 6'd32), 1);
        end
        while (q.size() > 0) begin
            free_list_read = 1'b1;
            chk("wrap_drain_tag", 32'(free_list_tag), 32'(q.pop_front()));
            tick();
        end
        free_list_read = 1'b0;
        chk("wrap_drain_empty", 32'(free_list_valid), 0);

        rst_n = 1'b0; flush = 1'b1;
        tick();
        rst_n = 1'b1; flush = 1'b0;
        chk("rst2_ovf", 32'(overflow_err), 0);
        chk("rst2_count", 32'(free_count), 0);
        chk("rst2_init_done", 32'(init_done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
